// File: rtl/bcd_ascii_streamer.sv
// Streams one latched BCD conversion result as an ASCII text line into a UART
// transmit port, with optional leading-zero suppression and CR LF terminator.
`timescale 1ns/1ps

// One digit lane: BCD nibble to ASCII, out-of-range nibbles become '?'.
module bcd_ascii_lane (
   input  logic [3:0] nib,
   output logic [7:0] ascii,
   output logic       is_zero
);
   assign ascii   = (nib > 4'd9) ? 8'h3F : {4'h3, nib};
   assign is_zero = (nib == 4'd0);
endmodule

module bcd_ascii_streamer #(
   parameter int NUM_DIGITS     = 10,
   parameter bit SUPPRESS_ZEROS = 1'b1,
   parameter bit APPEND_CRLF    = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [8*NUM_DIGITS-1:0] digits_i,
   output logic [7:0]              tx_data_o,
   output logic                    tx_valid_o,
   input  logic                    tx_ready_i,
   output logic                    busy_o,
   output logic                    done_o
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SEND, S_CR, S_LF, S_FIN} state_t;

   state_t                         state, state_nxt;
   logic [IDX_W-1:0]               idx, idx_nxt;
   logic [1:0]                     rst_pipe;
   logic                           rst_s;
   logic                           start_q, primed, trig, latch;
   logic [NUM_DIGITS-1:0][3:0]     dig_q;
   logic [NUM_DIGITS-1:0][7:0]     lane_ascii;
   logic [NUM_DIGITS-1:0]          lane_zero;

   // Reset asserts immediately, releases two clk_i edges after rst_i falls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_s = rst_pipe[1];

   // primed masks the first sample after reset so a level already high is not an edge.
   assign trig = start_i & ~start_q & primed;

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
         bcd_ascii_lane u_lane (
            .nib     (dig_q[g]),
            .ascii   (lane_ascii[g]),
            .is_zero (lane_zero[g])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_s) begin
      if (rst_s) begin
         state   <= S_IDLE;
         idx     <= '0;
         start_q <= 1'b0;
         primed  <= 1'b0;
         dig_q   <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         start_q <= start_i;
         primed  <= 1'b1;
         if (latch) begin
            for (int k = 0; k < NUM_DIGITS; k++) dig_q[k] <= digits_i[8*k +: 4];
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      latch      = 1'b0;
      tx_data_o  = 8'h00;
      tx_valid_o = 1'b0;
      busy_o     = 1'b1;
      done_o     = 1'b0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (trig) begin
               latch     = 1'b1;
               idx_nxt   = IDX_MSD;
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            // Digit 0 is never skipped so an all-zero value still prints "0".
            if (SUPPRESS_ZEROS && lane_zero[idx] && (idx != '0)) idx_nxt = idx - 1'b1;
            else                                                  state_nxt = S_SEND;
         end
         S_SEND: begin
            tx_valid_o = 1'b1;
            tx_data_o  = lane_ascii[idx];
            if (tx_ready_i) begin
               if (idx != '0)       idx_nxt   = idx - 1'b1;
               else if (APPEND_CRLF) state_nxt = S_CR;
               else                  state_nxt = S_FIN;
            end
         end
         S_CR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h0D;
            if (tx_ready_i) state_nxt = S_LF;
         end
         S_LF: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h0A;
            if (tx_ready_i) state_nxt = S_FIN;
         end
         S_FIN: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: doc/bcd_ascii_streamer.md
Name: bcd_ascii_streamer

Overview:
Downstream stage of the binary-to-BCD converter in the frequency-counter path. It takes the ten BCD digits of one completed conversion and streams them, most significant digit first, as ASCII bytes into the UART transmit interface. It uses a valid/ready byte handshake, optional leading-zero suppression and an optional CR LF terminator. One conversion result produces exactly one text line.

Parameters:
NUM_DIGITS, 10, number of BCD digits presented on digits_i; the index range is 0 (ones) to NUM_DIGITS-1 (most significant).
SUPPRESS_ZEROS, 1, when 1 leading zero digits are not sent; when 0 all NUM_DIGITS digits are sent.
APPEND_CRLF, 1, when 1 bytes 0x0D then 0x0A follow the last digit.

Ports:
clk_i  input  1  system clock; all logic is on the rising edge.
rst_i  input  1  asynchronous active-high reset.
start_i  input  1  connects to the converter's completion flag; only a rising edge triggers a line.
digits_i  input  8*NUM_DIGITS  digit k occupies bits [8k+7:8k]; bits [3:0] hold the BCD value and bits [7:4] are ignored.
tx_data_o  output  8  ASCII byte offered to the UART.
tx_valid_o  output  1  tx_data_o holds a byte.
tx_ready_i  input  1  the UART accepts the byte; a transfer occurs on a cycle where tx_valid_o and tx_ready_i are both 1.
busy_o  output  1  a line is in progress.
done_o  output  1  one-cycle pulse after the last byte of a line is transferred.

Behaviour:
- Reset (async assert, sync deassert by the clk_i domain) forces:
  - state IDLE; tx_data_o=0x00, tx_valid_o=0, busy_o=0, done_o=0;
  - start edge-detect register cleared, so start_i already high when reset is released does not trigger.
- Reset mid-line aborts immediately: the partial line is dropped and there is no done_o pulse.
- Start detection: a start register samples start_i each cycle; a trigger is start_i=1 with the registered value 0.
- A trigger is acted on only in IDLE. A trigger in any other state is ignored and is not queued.
- IDLE: on trigger, latch digits_i into an internal register, set index=NUM_DIGITS-1, go to SCAN, busy_o=1 from the next cycle. digits_i is not used after the latch.
- SCAN: one digit examined per cycle.
  - If SUPPRESS_ZEROS=1 and the latched digit[index]==0 and index!=0: index-=1 and stay in SCAN.
  - Otherwise go to SEND.
  - With SUPPRESS_ZEROS=0, SCAN always lasts exactly one cycle.
  - An all-zero value still sends a single '0' (digit 0 is never suppressed).
- SEND: tx_valid_o=1 and tx_data_o=0x30+digit[index].
  - A nibble value greater than 9 sends '?' (0x3F).
  - On transfer with index!=0: index-=1 and next byte is presented the following cycle (back-to-back transfers allowed; no bubble required).
  - Inner zeros are always sent.
  - On transfer with index==0: go to CR if APPEND_CRLF=1, else FIN.
- CR: present 0x0D; on transfer go to LF.
- LF: present 0x0A; on transfer go to FIN.
- FIN: tx_valid_o=0, done_o=1 for exactly one cycle, busy_o=0 from the next cycle, return to IDLE.
  - A trigger seen in FIN is ignored.
  - A trigger in the first IDLE cycle is accepted.
- Handshake rules:
  - While tx_valid_o=1 and tx_ready_i=0, tx_data_o and tx_valid_o hold stable.
  - tx_valid_o never drops without a transfer, except on reset.
  - tx_ready_i is ignored while tx_valid_o=0.
- Latency: the first tx_valid_o rises 2+Z cycles after the trigger cycle, where Z is the number of suppressed digits.
- Bytes per line: (number of significant digits, minimum 1) plus 2 if APPEND_CRLF=1.

Test Plan:
- digits of 1633837924 (0x61626364 after conversion), tx_ready_i held 1 -> bytes 31 36 33 33 38 33 37 39 32 34 0D 0A, back-to-back; then a single done_o pulse and busy_o falls.
- value 0 -> bytes 30 0D 0A; with SUPPRESS_ZEROS=0 -> ten 0x30 bytes then 0D 0A.
- value 1000005, tx_ready_i toggling 1/0 every cycle -> 31 30 30 30 30 30 35 0D 0A; inner zeros kept; tx_data_o stable whenever ready=0.
- start_i held high for 200 cycles across a full line -> exactly one line emitted; a second line only after start_i falls and rises again.
- second rising edge of start_i while SEND is stalled with ready=0 -> ignored; the line completes once and later changes to digits_i do not alter the bytes.
- rst_i asserted mid-SEND -> tx_valid_o=0, busy_o=0 asynchronously; no done_o pulse; the next trigger produces a complete fresh line. Also a nibble of 0xC -> byte 0x3F.
